// File: rtl/svi_cmp_sequencer_pkg.sv
// Shared types and constants for the x/y/z shared-net checker sequencer.
package svi_cmp_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
endpackage

// File: rtl/svi_cmp_sequencer_if.sv
// Control/result bundle between the sequencer and its host plus the two checker result bits.
interface svi_cmp_sequencer_if #(parameter int CNT_W = 8);
  logic             start;
  logic             abort;
  logic             b1;
  logic             b2;
  logic             x;
  logic             y;
  logic             z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [2:0]       first_err;

  modport master (
    output start, abort, b1, b2,
    input  x, y, z, busy, done, pass, err_cnt, first_err
  );

  modport slave (
    input  start, abort, b1, b2,
    output x, y, z, busy, done, pass, err_cnt, first_err
  );
endinterface

// File: rtl/svi_cmp_sequencer_stats.sv
// Mismatch statistics: saturating error counter, first-failing-vector capture, pass flag.
// All outputs registered; clear has priority over a same-cycle sample.
module svi_cmp_stats
  import svi_cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_vld,
  input  logic             mismatch,
  input  logic [VEC_W-1:0] vec,
  input  logic             finish,
  input  logic             aborted,
  output logic [CNT_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_err,
  output logic             pass
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else if (clear) begin
      err_cnt   <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else begin
      if (sample_vld && mismatch) begin
        if (err_cnt != '1)
          err_cnt <= err_cnt + CNT_W'(1);
        // Counter saturates rather than wraps, so zero reliably means "no mismatch yet".
        if (err_cnt == '0)
          first_err <= vec;
      end
      if (finish)
        pass <= (err_cnt == '0) && !aborted;
    end
  end

endmodule

// File: rtl/svi_cmp_sequencer.sv
// Sweeps x/y/z through all 8 vectors NUM_PASS times, samples both checkers after SETTLE_CYC cycles.
// done/pass/busy update on the edge leaving DONE: 8*NUM_PASS*(2+SETTLE_CYC)+1 cycles after start.
module svi_cmp_sequencer
  import svi_cmp_pkg::*;
#(
  parameter int NUM_PASS   = 1,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  svi_cmp_sequencer_if.slave  bus
);

  localparam int PW = (NUM_PASS > 1)   ? $clog2(NUM_PASS)   : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] xyz;
  logic [PW-1:0]    pass_cnt;
  logic [SW-1:0]    settle_cnt;
  logic             busy;
  logic             done;
  logic             aborted;

  logic start_run;
  logic abort_run;
  logic last_settle;
  logic last_vec;
  logic last_pass;
  logic sample_vld;

  assign start_run   = (state == IDLE) && bus.start && !bus.abort;
  assign abort_run   = bus.abort && (state != IDLE);
  assign last_settle = (int'(settle_cnt) >= SETTLE_CYC - 1);
  assign last_vec    = (vec == VEC_W'(NUM_VEC - 1));
  assign last_pass   = (int'(pass_cnt) == NUM_PASS - 1);
  // A sample coinciding with abort is dropped so the reported counts stop at the abort.
  assign sample_vld  = (state == SAMPLE) && !bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_run) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (last_settle) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (last_vec && last_pass) ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_run && (state != DONE))
      state_nxt = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      xyz        <= '0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start_run) begin
            busy     <= 1'b1;
            vec      <= '0;
            xyz      <= '0;
            pass_cnt <= '0;
            aborted  <= 1'b0;
          end
        end
        DRIVE: begin
          xyz        <= vec;
          settle_cnt <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        SAMPLE: begin
          if (!bus.abort) begin
            vec <= vec + VEC_W'(1);
            if (last_vec)
              pass_cnt <= pass_cnt + PW'(1);
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
      if (abort_run)
        aborted <= 1'b1;
    end
  end

  svi_cmp_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_run),
    .sample_vld (sample_vld),
    .mismatch   (bus.b1 ^ bus.b2),
    .vec        (vec),
    .finish     (state == DONE),
    .aborted    (aborted || bus.abort),
    .err_cnt    (bus.err_cnt),
    .first_err  (bus.first_err),
    .pass       (bus.pass)
  );

  assign bus.x    = xyz[2];
  assign bus.y    = xyz[1];
  assign bus.z    = xyz[0];
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_svi_cmp_sequencer.sv
// Directed bench: three sequencer configurations driven by behavioural checker models.
module tb_svi_cmp_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  svi_cmp_sequencer_if #(.CNT_W(8)) s1 ();
  svi_cmp_sequencer_if #(.CNT_W(8)) s2 ();
  svi_cmp_sequencer_if #(.CNT_W(8)) s3 ();

  svi_cmp_sequencer #(.NUM_PASS(1),  .SETTLE_CYC(2), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(s1));
  svi_cmp_sequencer #(.NUM_PASS(3),  .SETTLE_CYC(0), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(s2));
  svi_cmp_sequencer #(.NUM_PASS(40), .SETTLE_CYC(2), .CNT_W(8)) dut3 (.clk(clk), .rst(rst), .bus(s3));

  function automatic logic m1(input logic x, input logic y, input logic z);
    return ~y | (x ^ z);
  endfunction

  function automatic logic m2(input logic x, input logic y, input logic z);
    return (x ^ y) | (x ^ z);
  endfunction

  assign s1.b1 = m1(s1.x, s1.y, s1.z);
  assign s1.b2 = m2(s1.x, s1.y, s1.z);
  assign s2.b1 = m1(s2.x, s2.y, s2.z);
  assign s2.b2 = m1(s2.x, s2.y, s2.z);
  assign s3.b1 = 1'b1;
  assign s3.b2 = 1'b0;

  task automatic pulse_start(input int sel);
    @(negedge clk);
    case (sel)
      1: s1.start = 1'b1;
      2: s2.start = 1'b1;
      default: s3.start = 1'b1;
    endcase
    @(negedge clk);
    s1.start = 1'b0;
    s2.start = 1'b0;
    s3.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc);
    logic d;
    cyc = 0;
    d   = 1'b0;
    while (!d && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      case (sel)
        1: d = s1.done;
        2: d = s2.done;
        default: d = s3.done;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s1.start = 0; s1.abort = 0;
    s2.start = 0; s2.abort = 0;
    s3.start = 0; s3.abort = 0;
    repeat (3) @(negedge clk);
    checks++; if (s1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", s1.busy); end
    checks++; if (s1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", s1.done); end
    checks++; if (s1.pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b expected 0", s1.pass); end
    checks++; if (s1.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", s1.err_cnt); end
    checks++; if (s1.first_err !== 3'd0) begin errors++; $display("FAIL reset_first_err: got %0d expected 0", s1.first_err); end
    checks++; if ({s1.x, s1.y, s1.z} !== 3'd0) begin errors++; $display("FAIL reset_xyz: got %0d expected 0", {s1.x, s1.y, s1.z}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int cyc;
    int ntr;
    logic [2:0] prev;
    logic [2:0] cur;
    logic order_ok;
    pulse_start(1);
    checks++; if (s1.busy !== 1'b1) begin errors++; $display("FAIL sweep_busy: got %0b expected 1", s1.busy); end
    cyc = 0; ntr = 0; prev = 3'd0; order_ok = 1'b1;
    while (!s1.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      cur = {s1.x, s1.y, s1.z};
      if (cur != prev) begin
        ntr++;
        if (cur != 3'(ntr)) order_ok = 1'b0;
        prev = cur;
      end
    end
    checks++; if (cyc != 33) begin errors++; $display("FAIL sweep_latency: got %0d expected 33", cyc); end
    checks++; if (ntr != 7 || !order_ok) begin errors++; $display("FAIL sweep_order: got %0d steps ok=%0b expected 7 steps ok=1", ntr, order_ok); end
    checks++; if (s1.err_cnt !== 8'd2) begin errors++; $display("FAIL sweep_err_cnt: got %0d expected 2", s1.err_cnt); end
    checks++; if (s1.first_err !== 3'd0) begin errors++; $display("FAIL sweep_first_err: got %0d expected 0", s1.first_err); end
    checks++; if (s1.pass !== 1'b0) begin errors++; $display("FAIL sweep_pass: got %0b expected 0", s1.pass); end
    checks++; if (s1.busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_end: got %0b expected 0", s1.busy); end
    checks++; if ({s1.x, s1.y, s1.z} !== 3'd7) begin errors++; $display("FAIL sweep_hold_xyz: got %0d expected 7", {s1.x, s1.y, s1.z}); end
    @(negedge clk);
    checks++; if (s1.done !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse: got %0b expected 0", s1.done); end
  endtask

  task automatic test_no_settle();
    int cyc;
    pulse_start(2);
    wait_done(2, cyc);
    checks++; if (cyc != 49) begin errors++; $display("FAIL nosettle_latency: got %0d expected 49", cyc); end
    checks++; if (s2.err_cnt !== 8'd0) begin errors++; $display("FAIL nosettle_err_cnt: got %0d expected 0", s2.err_cnt); end
    checks++; if (s2.pass !== 1'b1) begin errors++; $display("FAIL nosettle_pass: got %0b expected 1", s2.pass); end
  endtask

  task automatic test_saturate();
    int cyc;
    pulse_start(3);
    wait_done(3, cyc);
    checks++; if (cyc != 1281) begin errors++; $display("FAIL sat_latency: got %0d expected 1281", cyc); end
    checks++; if (s3.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt: got %0d expected 255", s3.err_cnt); end
    checks++; if (s3.first_err !== 3'd0) begin errors++; $display("FAIL sat_first_err: got %0d expected 0", s3.first_err); end
    checks++; if (s3.pass !== 1'b0) begin errors++; $display("FAIL sat_pass: got %0b expected 0", s3.pass); end
  endtask

  task automatic test_abort();
    int cyc;
    pulse_start(1);
    cyc = 0;
    while ({s1.x, s1.y, s1.z} != 3'd3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc != 13) begin errors++; $display("FAIL abort_reach_v3: got %0d expected 13", cyc); end
    s1.abort = 1'b1;
    @(negedge clk);
    s1.abort = 1'b0;
    checks++; if (s1.done !== 1'b0) begin errors++; $display("FAIL abort_done_early: got %0b expected 0", s1.done); end
    @(negedge clk);
    checks++; if (s1.done !== 1'b1) begin errors++; $display("FAIL abort_done: got %0b expected 1", s1.done); end
    checks++; if (s1.pass !== 1'b0) begin errors++; $display("FAIL abort_pass: got %0b expected 0", s1.pass); end
    checks++; if (s1.err_cnt !== 8'd2) begin errors++; $display("FAIL abort_err_cnt: got %0d expected 2", s1.err_cnt); end
    checks++; if (s1.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", s1.busy); end
  endtask

  task automatic test_abort_idle();
    logic seen;
    @(negedge clk);
    s1.start = 1'b1;
    s1.abort = 1'b1;
    @(negedge clk);
    s1.start = 1'b0;
    s1.abort = 1'b0;
    checks++; if (s1.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %0b expected 0", s1.busy); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (s1.done || s1.busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_idle_run: got %0b expected 0", seen); end
  endtask

  task automatic test_back_to_back_start();
    int cyc;
    pulse_start(1);
    repeat (9) @(negedge clk);
    s1.start = 1'b1;
    @(negedge clk);
    s1.start = 1'b0;
    wait_done(1, cyc);
    cyc = cyc + 10;
    checks++; if (cyc != 33) begin errors++; $display("FAIL restart_latency: got %0d expected 33", cyc); end
    checks++; if (s1.err_cnt !== 8'd2) begin errors++; $display("FAIL restart_err_cnt: got %0d expected 2", s1.err_cnt); end
    checks++; if (s1.pass !== 1'b0) begin errors++; $display("FAIL restart_pass: got %0b expected 0", s1.pass); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic seen;
    pulse_start(1);
    repeat (7) @(negedge clk);
    checks++; if (s1.err_cnt !== 8'd1) begin errors++; $display("FAIL midrst_pre_err_cnt: got %0d expected 1", s1.err_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (s1.busy !== 1'b0 || s1.err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_clear: got busy=%0b err=%0d expected busy=0 err=0", s1.busy, s1.err_cnt); end
    checks++; if ({s1.x, s1.y, s1.z} !== 3'd0) begin errors++; $display("FAIL midrst_xyz: got %0d expected 0", {s1.x, s1.y, s1.z}); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (s1.done) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (s1.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %0b expected 0", seen); end
    pulse_start(1);
    wait_done(1, cyc);
    checks++; if (cyc != 33) begin errors++; $display("FAIL midrst_latency: got %0d expected 33", cyc); end
    checks++; if (s1.err_cnt !== 8'd2 || s1.first_err !== 3'd0) begin errors++; $display("FAIL midrst_rerun: got err=%0d first=%0d expected err=2 first=0", s1.err_cnt, s1.first_err); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_no_settle();
    test_saturate();
    test_abort();
    test_abort_idle();
    test_back_to_back_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
